// File: rtl/count_chk_pkg.sv
// count_chk_pkg: shared state encoding and default sizing for the count sequence checker.
package count_chk_pkg;
    typedef enum logic [1:0] {IDLE, TRACK, DONE, ERR} state_t;
    localparam int WIDTH_DEF  = 3;
    localparam int PASSES_DEF = 3;
endpackage

// File: rtl/count_chk_expect.sv
// count_chk_expect: expected-value register and completed-pass counter.
module count_chk_expect
    import count_chk_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int PASSES = PASSES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] expected,
    output logic [3:0]       pass_idx,
    output logic             wrap
);
    localparam logic [WIDTH-1:0] MAX = '1;

    // Advancing from the sampled value covers both a match and a resync.
    assign wrap = value == MAX;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            expected <= '0;
            pass_idx <= '0;
        end else if (advance) begin
            expected <= value + WIDTH'(1);
            if (wrap && pass_idx < 4'(PASSES))
                pass_idx <= pass_idx + 4'd1;
        end
    end
endmodule

// File: rtl/count_seq_checker.sv
// count_seq_checker: checks a 0..MAX count stream repeated PASSES times.
// Define COUNT_CHK_RESYNC_EN to resynchronise on mismatch and count errors on err_cnt.
module count_seq_checker
    import count_chk_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int PASSES = PASSES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_count,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_exp,
    output logic [WIDTH-1:0] err_got,
    output logic [3:0]       pass_idx
`ifdef COUNT_CHK_RESYNC_EN
    ,
    output logic [7:0]       err_cnt
`endif
);
`ifdef COUNT_CHK_RESYNC_EN
    localparam bit RESYNC = 1'b1;
`else
    localparam bit RESYNC = 1'b0;
`endif

    state_t state, state_nxt;
    logic [WIDTH-1:0] expected;
    logic sample, match, mismatch, advance, wrap, last;

    // A sample coinciding with start is dropped; start owns that cycle.
    assign sample   = state == TRACK && in_valid && !start;
    assign match    = in_count == expected;
    assign mismatch = sample && !match;
    assign advance  = sample && (match || RESYNC);
    assign last     = wrap && pass_idx == 4'(PASSES - 1);

    count_chk_expect #(.WIDTH(WIDTH), .PASSES(PASSES)) u_expect (
        .clk      (clk),
        .rst      (rst),
        .clear    (start),
        .advance  (advance),
        .value    (in_count),
        .expected (expected),
        .pass_idx (pass_idx),
        .wrap     (wrap)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = start ? TRACK :
                    (advance && last) ? DONE :
                    (mismatch && !RESYNC) ? ERR : state;
    end

    always_comb begin
        busy = state == TRACK;
        done = state == DONE;
    end

    always_ff @(posedge clk) begin
        if (rst || start) begin
            err     <= 1'b0;
            err_exp <= '0;
            err_got <= '0;
        end else if (mismatch) begin
            err <= 1'b1;
            if (!err) begin
                err_exp <= expected;
                err_got <= in_count;
            end
        end
    end

`ifdef COUNT_CHK_RESYNC_EN
    always_ff @(posedge clk) begin
        if (rst || start)
            err_cnt <= '0;
        else if (mismatch && err_cnt != 8'hff)
            err_cnt <= err_cnt + 8'd1;
    end
`endif
endmodule

// File: tb/tb_count_seq_checker.sv
// tb_count_seq_checker: directed checks of count_seq_checker (PASSES=3 and PASSES=1 instances).
module tb_count_seq_checker;
    logic clk, rst, start, in_valid;
    logic [2:0] in_count;
    logic busy, done, err;
    logic [2:0] err_exp, err_got;
    logic [3:0] pass_idx;
    logic busy1, done1, err1;
    logic [2:0] err_exp1, err_got1;
    logic [3:0] pass_idx1;
`ifdef COUNT_CHK_RESYNC_EN
    logic [7:0] err_cnt, err_cnt1;
`endif
    int checks = 0;
    int errors = 0;

    count_seq_checker #(.WIDTH(3), .PASSES(3)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_count(in_count),
        .busy(busy), .done(done), .err(err), .err_exp(err_exp), .err_got(err_got),
        .pass_idx(pass_idx)
`ifdef COUNT_CHK_RESYNC_EN
        , .err_cnt(err_cnt)
`endif
    );

    count_seq_checker #(.WIDTH(3), .PASSES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_count(in_count),
        .busy(busy1), .done(done1), .err(err1), .err_exp(err_exp1), .err_got(err_got1),
        .pass_idx(pass_idx1)
`ifdef COUNT_CHK_RESYNC_EN
        , .err_cnt(err_cnt1)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge, after the posedge consumed the inputs.
    task automatic drive(input logic v, input logic [2:0] c);
        in_valid = v;
        in_count = c;
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        drive(1'b1, 3'd5);
        start = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_err_exp"}, int'(err_exp), 0);
        chk({tag, "_err_got"}, int'(err_got), 0);
        chk({tag, "_pass"}, int'(pass_idx), 0);
`ifdef COUNT_CHK_RESYNC_EN
        chk({tag, "_err_cnt"}, int'(err_cnt), 0);
`endif
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_count = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("reset");

        // Clean three-pass stream
        do_start();
        chk("t1_busy", int'(busy), 1);
        for (int p = 0; p < 3; p++)
            for (int v = 0; v < 8; v++) begin
                drive(1'b1, 3'(v));
                if (p == 0 && v == 6) chk("t6_done1_early", int'(done1), 0);
                if (p == 0 && v == 7) chk("t6_done1", int'(done1), 1);
                if (p == 1 && v == 0) chk("t1_pass1", int'(pass_idx), 1);
                if (p == 2 && v == 6) chk("t1_done_early", int'(done), 0);
            end
        drive(1'b0, 3'd0);
        chk("t1_done", int'(done), 1);
        chk("t1_pass", int'(pass_idx), 3);
        chk("t1_err", int'(err), 0);
        chk("t1_busy_end", int'(busy), 0);
        chk("t6_pass1", int'(pass_idx1), 1);

        // Same stream with gaps, then terminal hold value
        do_start();
        chk("t2_done_clr", int'(done), 0);
        chk("t2_pass_clr", int'(pass_idx), 0);
        for (int i = 0; i < 24; i++) begin
            drive(1'b1, 3'(i % 8));
            repeat (1 + i % 3) drive(1'b0, 3'(i + 3));
        end
        chk("t2_done", int'(done), 1);
        chk("t2_pass", int'(pass_idx), 3);
        repeat (10) drive(1'b1, 3'd7);
        drive(1'b0, 3'd0);
        chk("t2_hold_done", int'(done), 1);
        chk("t2_hold_err", int'(err), 0);
        chk("t2_hold_pass", int'(pass_idx), 3);

        // Mismatch 0,1,2,4
        do_start();
        drive(1'b1, 3'd0);
        drive(1'b1, 3'd1);
        drive(1'b1, 3'd2);
        drive(1'b1, 3'd4);
        in_valid = 1'b0;
        chk("t3_err", int'(err), 1);
        chk("t3_err_exp", int'(err_exp), 3);
        chk("t3_err_got", int'(err_got), 4);
`ifdef COUNT_CHK_RESYNC_EN
        chk("t3_err_cnt", int'(err_cnt), 1);
        chk("t3_busy", int'(busy), 1);
        drive(1'b1, 3'd5);
        drive(1'b1, 3'd6);
        drive(1'b1, 3'd7);
        in_valid = 1'b0;
        chk("t3_resync_pass", int'(pass_idx), 1);
        chk("t3_resync_err_cnt", int'(err_cnt), 1);
`else
        chk("t3_busy", int'(busy), 0);
        drive(1'b1, 3'd5);
        drive(1'b1, 3'd0);
        in_valid = 1'b0;
        chk("t3_err_exp_hold", int'(err_exp), 3);
        chk("t3_err_got_hold", int'(err_got), 4);
        chk("t3_busy_hold", int'(busy), 0);
`endif
        do_start();
        chk("t3_rearm_err", int'(err), 0);
        chk("t3_rearm_exp", int'(err_exp), 0);
        chk("t3_rearm_got", int'(err_got), 0);
        chk("t3_rearm_busy", int'(busy), 1);

        // Reset mid-stream
        do_start();
        for (int v = 0; v < 11; v++) drive(1'b1, 3'(v % 8));
        rst = 1'b1;
        drive(1'b1, 3'd3);
        rst = 1'b0;
        chk_reset_vals("t4_rst");
        for (int v = 0; v < 8; v++) drive(1'b1, 3'(v));
        drive(1'b0, 3'd0);
        chk_reset_vals("t4_ignore");

        // Restart in the middle of a stream
        do_start();
        for (int v = 0; v < 12; v++) drive(1'b1, 3'(v % 8));
        chk("t5_pass_mid", int'(pass_idx), 1);
        do_start();
        chk("t5_pass_clr", int'(pass_idx), 0);
        chk("t5_busy", int'(busy), 1);
        for (int i = 0; i < 24; i++) begin
            drive(1'b1, 3'(i % 8));
            if (i == 7) chk("t6_done1_restart", int'(done1), 1);
        end
        drive(1'b0, 3'd0);
        chk("t5_done", int'(done), 1);
        chk("t5_err", int'(err), 0);
        chk("t5_pass", int'(pass_idx), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
